// File: rtl/fire_pkg.sv
// Shared types and sizing helpers for the fire-module conv sequencer.
// Holds the sequencer state enum plus tap-count and counter-width helpers.
package fire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    EMIT,
    DONE
  } fire_seq_state_t;

  function automatic int taps_f(input int kd, input int chin);
    return kd * kd * chin;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fire_lat_pipe.sv
// Parameterised 1-bit delay line (LAT register stages, LAT=0 is a wire).
// Ports: clk, rst (async active-low), d_i in, q_o delayed out.
module fire_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (LAT == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [LAT-1:0] sr_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr_q <= '0;
      end else begin
        sr_q <= LAT'({sr_q, d_i});
      end
    end

    assign q_o = sr_q[LAT-1];
  end

endmodule

// File: rtl/fire_conv_sequencer.sv
// Control sequencer for one fire-module conv MAC array: weight-ROM walk,
// MAC enable/clear, ofm strobe, pixel count and finish/feedback handshake.
// Ports: clk, rst (async active-low), start, ifm_valid/ifm_ready,
// rom_addr, mac_en, mac_clr, ofm_valid/ofm_ready, pix_idx, busy,
// ram_feedback, finish.
// Build option FIRE_SEQ_BACKPRESSURE_EN: EMIT waits for ofm_ready;
// otherwise ofm_valid is a one-cycle pulse and ofm_ready is unused.
module fire_conv_sequencer
  import fire_pkg::*;
#(
  parameter  int WOUT       = 8,
  parameter  int CHIN       = 112,
  parameter  int KERNEL_DIM = 3,
  parameter  int ROM_LAT    = 1,
  parameter  int MAC_LAT    = 2,
  localparam int TAPS       = taps_f(KERNEL_DIM, CHIN),
  localparam int NPIX       = WOUT * WOUT,
  localparam int AW         = cnt_w(TAPS),
  localparam int PW         = cnt_w(NPIX + 1),
  localparam int DLAT       = ROM_LAT + MAC_LAT,
  localparam int DW         = cnt_w(DLAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ifm_valid,
  output logic          ifm_ready,
  output logic [AW-1:0] rom_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          ofm_valid,
  input  logic          ofm_ready,
  output logic [PW-1:0] pix_idx,
  output logic          busy,
  input  logic          ram_feedback,
  output logic          finish
);

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [DW-1:0] DR_INIT  = DW'(DLAT - 1);

  fire_seq_state_t state_q, state_d;
  logic [AW-1:0]   tap_q, tap_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            done_q, done_d;
  logic            fb_q, fb_d;
  logic            clr_q, clr_d;
  logic            ovld_q, ovld_d;
  logic            busy_q, busy_d;
  logic            fin_q, fin_d;
  logic            accept;
  logic            hs;

  assign ifm_ready = (state_q == ACCUM);
  assign accept    = ifm_valid && ifm_ready;

`ifdef FIRE_SEQ_BACKPRESSURE_EN
  assign hs = (state_q == EMIT) && ofm_ready;
`else
  logic unused_ofm_ready;
  assign unused_ofm_ready = ofm_ready;
  assign hs = (state_q == EMIT);
`endif

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    drain_d = drain_q;
    pix_d   = pix_q;
    done_d  = done_q;
    fb_d    = fb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          tap_d   = '0;
          pix_d   = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (tap_q == LAST_TAP) begin
            tap_d   = '0;
            drain_d = DR_INIT;
            state_d = DRAIN;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = EMIT;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      EMIT: begin
        if (hs) begin
          if (pix_q == LAST_PIX) begin
            pix_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // start beats a same-cycle ram_feedback
        if (start) begin
          state_d = ACCUM;
          done_d  = 1'b0;
          fb_d    = 1'b0;
          tap_d   = '0;
          pix_d   = '0;
        end else if (ram_feedback && done_q) begin
          fb_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM) || (state_d == DRAIN) ||
             (state_d == EMIT);
    ovld_d = (state_d == EMIT);
    clr_d  = hs;
    fin_d  = done_d && !fb_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      drain_q <= '0;
      pix_q   <= '0;
      done_q  <= 1'b0;
      fb_q    <= 1'b0;
      clr_q   <= 1'b0;
      ovld_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      drain_q <= drain_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
      fb_q    <= fb_d;
      clr_q   <= clr_d;
      ovld_q  <= ovld_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  // accept strobe lines up with ROM data
  fire_lat_pipe #(
    .LAT (ROM_LAT)
  ) u_en_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (accept),
    .q_o (mac_en)
  );

  assign rom_addr  = tap_q;
  assign mac_clr   = clr_q;
  assign ofm_valid = ovld_q;
  assign pix_idx   = pix_q;
  assign busy      = busy_q;
  assign finish    = fin_q;

endmodule
